// File: rtl/y86_pkg.sv
// ----------------------------------------------------------------------------
// y86_pkg -- shared definitions for the Y86-64 execute stage.
//
// Contents:
//   I_*      instruction codes (icode)
//   ALU_*    OPq function codes (ifun when icode == I_OPQ)
//   C_*      condition function codes (ifun for cmovXX / jXX)
//   cc_t     condition-code register layout {zf, sf, of}
//   CC_RESET value loaded into the CC register on reset
//   eval_cond() condition evaluation from a CC value and ifun
// ----------------------------------------------------------------------------
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    // Unknown condition codes (ifun > 6) evaluate false.
    function automatic logic eval_cond(input cc_t cc, input logic [3:0] fn);
        logic lt;
        lt = cc.sf ^ cc.of;
        case (fn)
            C_ALWAYS: eval_cond = 1'b1;
            C_LE:     eval_cond = lt | cc.zf;
            C_L:      eval_cond = lt;
            C_E:      eval_cond = cc.zf;
            C_NE:     eval_cond = ~cc.zf;
            C_GE:     eval_cond = ~lt;
            C_G:      eval_cond = ~lt & ~cc.zf;
            default:  eval_cond = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_alu.sv
// ----------------------------------------------------------------------------
// y86_alu -- combinational 64-bit ALU for the Y86-64 execute stage.
//
// Computes result = alu_b OP alu_a (operand order matches Y86 "OPq rA, rB",
// where rB is the destination) and the flags that result would set.
//
// Ports:
//   alu_a   [WORD_W-1:0] in   operand A (subtrahend for SUB)
//   alu_b   [WORD_W-1:0] in   operand B
//   alu_op  [3:0]        in   ALU_ADD / ALU_SUB / ALU_AND / ALU_XOR
//   result  [WORD_W-1:0] out  result; 0 for unsupported op codes
//   zf, sf, of           out  zero, sign and signed-overflow flags
// ----------------------------------------------------------------------------
module y86_alu
    import y86_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic [WORD_W-1:0] alu_a,
    input  logic [WORD_W-1:0] alu_b,
    input  logic [3:0]        alu_op,
    output logic [WORD_W-1:0] result,
    output logic              zf,
    output logic              sf,
    output logic              of
);

    localparam int MSB = WORD_W - 1;

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result = alu_b + alu_a;
                // Same-sign operands producing a result of the other sign.
                of     = (alu_a[MSB] == alu_b[MSB]) && (result[MSB] != alu_b[MSB]);
            end
            ALU_SUB: begin
                result = alu_b - alu_a;
                // Opposite-sign operands where the result sign leaves alu_b's.
                of     = (alu_a[MSB] != alu_b[MSB]) && (result[MSB] != alu_b[MSB]);
            end
            ALU_AND: result = alu_b & alu_a;
            ALU_XOR: result = alu_b ^ alu_a;
            default: result = '0;
        endcase
        zf = (result == '0);
        sf = result[MSB];
    end

endmodule

// File: rtl/y86_execute.sv
// ----------------------------------------------------------------------------
// y86_execute -- Y86-64 execute stage: operand muxing, condition-code
// register and condition evaluation around a single shared ALU.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset (CC <= ZF=1, SF=0, OF=0)
//   icode[3:0] in   instruction code
//   ifun[3:0]  in   function code (ALU op or condition)
//   valA, valB, valC [63:0] in  register operands and immediate
//   valE[63:0] out  execute result, combinational
//   cond_flag  out  condition result from registered CC (icode 2 / 7 only)
//   cc[2:0]    out  {ZF,SF,OF} straight from the CC register; present only
//                   when the macro EXEC_CC_OUT_EN is defined
// ----------------------------------------------------------------------------
module y86_execute
    import y86_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [WORD_W-1:0] valA,
    input  logic [WORD_W-1:0] valB,
    input  logic [WORD_W-1:0] valC,
    output logic [WORD_W-1:0] valE,
    output logic              cond_flag
`ifdef EXEC_CC_OUT_EN
    ,
    output logic [2:0]        cc
`endif
);

    localparam logic [WORD_W-1:0] STACK_STEP = WORD_W'(8);

    logic [WORD_W-1:0] alu_a;
    logic [WORD_W-1:0] alu_b;
    logic [3:0]        alu_op;
    logic [WORD_W-1:0] alu_result;
    logic              alu_zf;
    logic              alu_sf;
    logic              alu_of;

    cc_t               cc_reg;
    cc_t               cc_next;
    logic              cc_update;

    // Every icode is routed through the ALU; moves add to zero, stack ops
    // add or subtract 8, unknown icodes add 0 + 0 so valE falls out as 0.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_ADD;
        case (icode)
            I_RRMOVQ: alu_a = valA;
            I_IRMOVQ: alu_a = valC;
            I_RMMOVQ, I_MRMOVQ: begin
                alu_a = valC;
                alu_b = valB;
            end
            I_OPQ: begin
                alu_a  = valA;
                alu_b  = valB;
                alu_op = ifun;
            end
            I_CALL, I_PUSHQ: begin
                alu_a  = STACK_STEP;
                alu_b  = valB;
                alu_op = ALU_SUB;
            end
            I_RET, I_POPQ: begin
                alu_a = STACK_STEP;
                alu_b = valB;
            end
            default: begin
                alu_a  = '0;
                alu_b  = '0;
                alu_op = ALU_ADD;
            end
        endcase
    end

    y86_alu #(
        .WORD_W (WORD_W)
    ) u_alu (
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .result (alu_result),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    assign valE = alu_result;

    // Only a valid OPq writes CC; OPq with an unknown ifun leaves it alone.
    assign cc_update = (icode == I_OPQ) && (ifun <= ALU_XOR);
    assign cc_next   = '{zf: alu_zf, sf: alu_sf, of: alu_of};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_reg <= CC_RESET;
        end else if (cc_update) begin
            cc_reg <= cc_next;
        end
    end

    // Conditions look at the registered CC, i.e. flags from the previous OPq.
    always_comb begin
        cond_flag = 1'b0;
        if ((icode == I_RRMOVQ) || (icode == I_JXX)) begin
            cond_flag = eval_cond(cc_reg, ifun);
        end
    end

`ifdef EXEC_CC_OUT_EN
    assign cc = {cc_reg.zf, cc_reg.sf, cc_reg.of};
`endif

endmodule

// File: tb/tb_y86_execute.sv
// ----------------------------------------------------------------------------
// tb_y86_execute -- self-checking bench for y86_execute.
// Each transaction pushes its expected {valE, cond_flag} onto a scoreboard
// when driven; a negedge monitor pops and compares against the DUT.
// ----------------------------------------------------------------------------
module tb_y86_execute;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        cond_flag;
`ifdef EXEC_CC_OUT_EN
    logic [2:0]  cc;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [63:0] exp_vale;
        logic        exp_cond;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    y86_execute #(
        .WORD_W (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .icode     (icode),
        .ifun      (ifun),
        .valA      (valA),
        .valB      (valB),
        .valC      (valC),
        .valE      (valE),
        .cond_flag (cond_flag)
`ifdef EXEC_CC_OUT_EN
        ,
        .cc        (cc)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Drive one instruction for one cycle; caller sits just after a posedge.
    task automatic send(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic [63:0] ev, input logic ec);
        exp_t e;
        icode = ic;
        ifun  = fn;
        valA  = a;
        valB  = b;
        valC  = c;
        e.tag      = tag;
        e.exp_vale = ev;
        e.exp_cond = ec;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            $display("txn %-14s icode=%h ifun=%h valE=0x%016h cond=%0b", e.tag, icode, ifun, valE, cond_flag);
            check_val({e.tag, ".valE"}, valE, e.exp_vale);
            check_val({e.tag, ".cond"}, {63'd0, cond_flag}, {63'd0, e.exp_cond});
        end
    end

    initial begin
        rst_n = 1'b0;
        icode = 4'h7;
        ifun  = 4'h3;
        valA  = '0;
        valB  = '0;
        valC  = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state: ZF=1 SF=0 OF=0
        send("rst_je",     4'h7, 4'h3, 0, 0, 0, 64'd0, 1'b1);
        send("rst_jne",    4'h7, 4'h4, 0, 0, 0, 64'd0, 1'b0);
        send("rst_jmp",    4'h7, 4'h0, 0, 0, 0, 64'd0, 1'b1);

        // OPq
        send("addq",       4'h6, 4'h0, 64'd10, 64'd15, 0, 64'd25, 1'b0);
        send("jg_after",   4'h7, 4'h6, 0, 0, 0, 64'd0, 1'b1);
        send("subq",       4'h6, 4'h1, 64'd10, 64'd31, 0, 64'd21, 1'b0);
        send("xorq",       4'h6, 4'h3, 64'd12, 64'd4, 0, 64'd8, 1'b0);
        send("jne_nz",     4'h7, 4'h4, 0, 0, 0, 64'd0, 1'b1);

        // Zero flag
        send("andq_zero",  4'h6, 4'h2, 64'd10, 64'd5, 0, 64'd0, 1'b0);
        send("je_z",       4'h7, 4'h3, 0, 0, 0, 64'd0, 1'b1);
        send("jne_z",      4'h7, 4'h4, 0, 0, 0, 64'd0, 1'b0);

        // Invalid OPq ifun: valE 0, CC untouched (ZF stays 1)
        send("opq_bad",    4'h6, 4'h5, 64'd3, 64'd7, 0, 64'd0, 1'b0);
        send("je_keep",    4'h7, 4'h3, 0, 0, 0, 64'd0, 1'b1);

        // Moves
        send("irmovq",     4'h3, 4'h0, 0, 0, 64'd230, 64'd230, 1'b0);
        send("rrmovq",     4'h2, 4'h0, 64'd200, 0, 0, 64'd200, 1'b1);
        send("cmovne",     4'h2, 4'h4, 64'd200, 0, 0, 64'd200, 1'b0);
        send("rmmovq",     4'h4, 4'h0, 0, 64'd200, 64'd8, 64'd208, 1'b0);
        send("mrmovq",     4'h5, 4'h0, 0, 64'd547, 64'd16, 64'd563, 1'b0);

        // Stack
        send("call",       4'h8, 4'h0, 0, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        send("popq",       4'hB, 4'h0, 0, 64'd0, 0, 64'd8, 1'b0);
        send("pushq",      4'hA, 4'h0, 0, 64'h100, 0, 64'hF8, 1'b0);
        send("ret",        4'h9, 4'h0, 0, 64'h40, 0, 64'h48, 1'b0);
        send("je_stack",   4'h7, 4'h3, 0, 0, 0, 64'd0, 1'b1);
        send("jl_stack",   4'h7, 4'h2, 0, 0, 0, 64'd0, 1'b0);

        // Other icodes
        send("halt",       4'h0, 4'h0, 64'd5, 64'd6, 64'd7, 64'd0, 1'b0);
        send("nop",        4'h1, 4'h0, 64'd5, 64'd6, 64'd7, 64'd0, 1'b0);
        send("icode_f",    4'hF, 4'h0, 64'd5, 64'd6, 64'd7, 64'd0, 1'b0);
        send("jxx_ifun7",  4'h7, 4'h7, 0, 0, 0, 64'd0, 1'b0);

        // Overflow
        send("add_ovf",    4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 64'h8000_0000_0000_0000, 1'b0);
        send("jl_ovf",     4'h7, 4'h2, 0, 0, 0, 64'd0, 1'b0);
        send("jge_ovf",    4'h7, 4'h5, 0, 0, 0, 64'd0, 1'b1);
        send("jle_ovf",    4'h7, 4'h1, 0, 0, 0, 64'd0, 1'b0);
        send("sub_ovf",    4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        send("jl_subovf",  4'h7, 4'h2, 0, 0, 0, 64'd0, 1'b1);

        // Reset wins over an OPq in the same cycle; valE still combinational
        rst_n = 1'b0;
        send("add_in_rst", 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 64'h8000_0000_0000_0000, 1'b0);
        rst_n = 1'b1;
        send("je_postrst", 4'h7, 4'h3, 0, 0, 0, 64'd0, 1'b1);
        send("jl_postrst", 4'h7, 4'h2, 0, 0, 0, 64'd0, 1'b0);
        send("jg_postrst", 4'h7, 4'h6, 0, 0, 0, 64'd0, 1'b0);

        @(negedge clk);
        check_val("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
